// File: rtl/act_c2_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated ACT C2 logic cell:
// FSM encodings and the field offsets inside each requester's cfg_data/cfg_sel slice.
package act_c2_arbiter_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // cfg_sel slice layout {A1,B1,A0,B0}
  localparam int unsigned SelB0 = 0;
  localparam int unsigned SelA0 = 1;
  localparam int unsigned SelB1 = 2;
  localparam int unsigned SelA1 = 3;
  localparam int unsigned SelW  = 4;

  // cfg_data slice layout {D11,D10,D01,D00}, field index in units of BITS
  localparam int unsigned FldD00   = 0;
  localparam int unsigned FldD01   = 1;
  localparam int unsigned FldD10   = 2;
  localparam int unsigned FldD11   = 3;
  localparam int unsigned DataFlds = 4;

endpackage

// File: rtl/act_c2_cell.sv
// Combinational ACT C2 cell: S0 = A0 & B0, S1 = A1 | B1, {S0,S1} selects D00..D11.
module act_c2_cell import act_c2_arbiter_pkg::*; #(
  parameter int unsigned BITS = 2
) (
  input  logic [DataFlds*BITS-1:0] data,
  input  logic [SelW-1:0]          sel,
  output logic [BITS-1:0]          y
);

  logic s0, s1;

  assign s0 = sel[SelA0] & sel[SelB0];
  assign s1 = sel[SelA1] | sel[SelB1];

  always_comb begin
    y = data[FldD00*BITS +: BITS];
    case ({s0, s1})
      2'b01:   y = data[FldD01*BITS +: BITS];
      2'b10:   y = data[FldD10*BITS +: BITS];
      2'b11:   y = data[FldD11*BITS +: BITS];
      default: y = data[FldD00*BITS +: BITS];
    endcase
  end

endmodule

// File: rtl/act_c2_arbiter.sv
// Round-robin arbiter sharing one ACT C2 cell among N_REQ requesters.
// Grant and operand capture happen together; the registered result follows one cycle later.
module act_c2_arbiter import act_c2_arbiter_pkg::*; #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BITS  = 2,
  localparam int unsigned IDW  = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DataFlds*BITS-1:0] cfg_data,
  input  logic [N_REQ*SelW-1:0]         cfg_sel,
  output logic [N_REQ-1:0]              gnt,
  output logic                          busy,
  output logic [BITS-1:0]               result,
  output logic                          result_valid,
  output logic [IDW-1:0]                result_id
);

  logic [1:0]               state_q;
  logic [N_REQ-1:0]         gnt_q;
  logic                     busy_q;
  logic [BITS-1:0]          result_q;
  logic                     result_valid_q;
  logic [IDW-1:0]           result_id_q;
  logic [IDW-1:0]           last_q;
  logic [IDW-1:0]           grant_idx_q;
  logic [DataFlds*BITS-1:0] op_data_q;
  logic [SelW-1:0]          op_sel_q;

  logic                     pick_valid;
  logic [IDW-1:0]           pick_idx;
  logic [IDW-1:0]           cand;
  logic [BITS-1:0]          cell_y;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDW'((32'(last_q) + off) % N_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  act_c2_cell #(
    .BITS (BITS)
  ) u_cell (
    .data (op_data_q),
    .sel  (op_sel_q),
    .y    (cell_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      gnt_q          <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      last_q         <= IDW'(N_REQ - 1);
      grant_idx_q    <= '0;
      op_data_q      <= '0;
      op_sel_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        StIdle, StResp: begin
          if (pick_valid) begin
            state_q     <= StEval;
            gnt_q       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            busy_q      <= 1'b1;
            last_q      <= pick_idx;
            grant_idx_q <= pick_idx;
            op_data_q   <= (DataFlds*BITS)'(cfg_data >> (32'(pick_idx) * DataFlds * BITS));
            op_sel_q    <= SelW'(cfg_sel >> (32'(pick_idx) * SelW));
          end else begin
            state_q <= StIdle;
          end
        end
        StEval: begin
          state_q        <= StResp;
          result_q       <= cell_y;
          result_valid_q <= 1'b1;
          result_id_q    <= grant_idx_q;
          gnt_q          <= '0;
          busy_q         <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;

endmodule

// File: tb/tb_act_c2_arbiter.sv
// Directed bench for act_c2_arbiter with a grant/result scoreboard checked on the falling edge.
module tb_act_c2_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Bits = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NReq-1:0]        req;
  logic [NReq*4*Bits-1:0] cfg_data;
  logic [NReq*4-1:0]      cfg_sel;
  logic [NReq-1:0]        gnt;
  logic                   busy;
  logic [Bits-1:0]        result;
  logic                   result_valid;
  logic [1:0]             result_id;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_gnt_q[$];
  logic [3:0] exp_res_q[$];  // {id, result}

  act_c2_arbiter #(
    .N_REQ (NReq),
    .BITS  (Bits)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cfg_data     (cfg_data),
    .cfg_sel      (cfg_sel),
    .gnt          (gnt),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cell_model(input logic [7:0] d, input logic [3:0] s);
    logic s0, s1;
    s0 = s[1] & s[0];
    s1 = s[3] | s[2];
    case ({s0, s1})
      2'b00:   return d[1:0];
      2'b01:   return d[3:2];
      2'b10:   return d[5:4];
      default: return d[7:6];
    endcase
  endfunction

  task automatic expect_grant(input int id, input bit with_result);
    logic [7:0] d;
    logic [3:0] s;
    d = 8'(cfg_data >> (id * 8));
    s = 4'(cfg_sel >> (id * 4));
    exp_gnt_q.push_back(4'(1 << id));
    if (with_result) exp_res_q.push_back({2'(id), cell_model(d, s)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (gnt !== '0) begin
      if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
      else check("gnt_sb", 32'(gnt), 32'(exp_gnt_q.pop_front()));
    end
    if (result_valid !== 1'b0) begin
      if (exp_res_q.size() == 0) check("valid_unexpected", 32'(result_valid), 32'd0);
      else check("result_sb", 32'({result_id, result}), 32'(exp_res_q.pop_front()));
    end
  end

  initial begin
    logic [3:0] sels[3];
    logic [1:0] sel_res[3];
    sels    = '{4'b0000, 4'b1011, 4'b0100};
    sel_res = '{2'b00, 2'b11, 2'b01};

    rst_n    = 1'b0;
    req      = '0;
    cfg_data = '0;
    cfg_sel  = '0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_id", 32'(result_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single grant to requester 2
    cfg_data = {8'b0, 8'b11_10_01_00, 16'b0};
    cfg_sel  = {4'b0, 4'b0011, 8'b0};
    req      = 4'b0100;
    expect_grant(2, 1'b1);
    tick();
    check("sg_gnt", 32'(gnt), 32'h4);
    check("sg_busy", 32'(busy), 32'd1);
    check("sg_valid_early", 32'(result_valid), 32'd0);
    req = '0;
    tick();
    check("sg_valid", 32'(result_valid), 32'd1);
    check("sg_result", 32'(result), 32'h2);
    check("sg_id", 32'(result_id), 32'd2);
    check("sg_gnt_clr", 32'(gnt), 32'd0);
    check("sg_busy_clr", 32'(busy), 32'd0);
    tick();
    check("sg_valid_clr", 32'(result_valid), 32'd0);
    check("sg_result_hold", 32'(result), 32'h2);

    // Select combinations on the same data
    for (int i = 0; i < 3; i++) begin
      cfg_sel = {4'b0, sels[i], 8'b0};
      req     = 4'b0100;
      expect_grant(2, 1'b1);
      tick();
      req = '0;
      tick();
      check("sel_result", 32'(result), 32'(sel_res[i]));
      tick();
    end

    // Fairness under continuous full request
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    cfg_data = {8'hE4, 8'h1B, 8'h9C, 8'h72};
    cfg_sel  = {4'b0011, 4'b1000, 4'b0101, 4'b0010};
    expect_grant(0, 1'b1);
    expect_grant(1, 1'b1);
    expect_grant(2, 1'b1);
    expect_grant(3, 1'b1);
    expect_grant(0, 1'b1);
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      check("fair_gnt", 32'(gnt), 32'(1 << (g % 4)));
      check("fair_valid_low", 32'(result_valid), 32'd0);
      if (g == 4) req = '0;
      tick();
      check("fair_valid", 32'(result_valid), 32'd1);
      check("fair_id", 32'(result_id), 32'(g % 4));
      tick();
    end
    check("fair_idle_busy", 32'(busy), 32'd0);
    check("fair_idle_gnt", 32'(gnt), 32'd0);

    // Withdrawal: req[1] pulses only while requester 0 evaluates
    req = 4'b0001;
    expect_grant(0, 1'b1);
    tick();
    check("wd_gnt", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    req = '0;
    check("wd_valid", 32'(result_valid), 32'd1);
    check("wd_id", 32'(result_id), 32'd0);
    tick();
    check("wd_idle_gnt", 32'(gnt), 32'd0);
    check("wd_idle_busy", 32'(busy), 32'd0);
    tick();
    check("wd_still_idle", 32'(busy), 32'd0);

    // Reset during evaluation of requester 1
    req = 4'b0010;
    expect_grant(1, 1'b0);
    tick();
    check("rm_gnt", 32'(gnt), 32'h2);
    req = '0;
    #6;
    rst_n = 1'b0;
    #1;
    check("rm_gnt_zero", 32'(gnt), 32'd0);
    check("rm_busy_zero", 32'(busy), 32'd0);
    check("rm_valid_zero", 32'(result_valid), 32'd0);
    check("rm_result_zero", 32'(result), 32'd0);
    check("rm_id_zero", 32'(result_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_no_valid", 32'(result_valid), 32'd0);
    tick();
    check("rm_no_valid2", 32'(result_valid), 32'd0);
    req = 4'b1111;
    expect_grant(0, 1'b1);
    tick();
    check("rm_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("rm_first_id", 32'(result_id), 32'd0);
    tick();
    tick();

    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
    check("res_queue_drained", 32'(exp_res_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
